// File: rtl/iq_loopback_channel.sv
// rtl/iq_loopback_channel.sv - DAC-to-ADC I/Q loopback emulator: delay, rotation, attenuation, offset, noise
// Define CHAN_SATURATE_EN to clip the output sum instead of wrapping it.
module iq_loopback_channel #(
  parameter int          DW        = 12,
  parameter int          MAX_DELAY = 64,
  parameter int          NOISE_W   = 6,
  parameter logic [15:0] SEED_I    = 16'hACE1,
  parameter logic [15:0] SEED_Q    = 16'h1D2B
) (
  input  logic                         clk_16M384,
  input  logic                         rst_16M384,
  input  logic signed [DW-1:0]         DAC_I,
  input  logic signed [DW-1:0]         DAC_Q,
  input  logic                         DAC_vld,
  input  logic [$clog2(MAX_DELAY)-1:0] DELAY,
  input  logic [1:0]                   ROT,
  input  logic [2:0]                   GAIN_SHIFT,
  input  logic signed [DW-1:0]         DC_OFFSET,
  input  logic                         NOISE_EN,
  output logic signed [DW-1:0]         ADC_I,
  output logic signed [DW-1:0]         ADC_Q,
  output logic                         ADC_vld,
  output logic                         SAT_FLAG
);

  localparam int          AW        = $clog2(MAX_DELAY);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
`ifdef CHAN_SATURATE_EN
  localparam int SW      = DW + 3;
  localparam int SAT_MAX = 2**(DW-1) - 1;
  localparam int SAT_MIN = -(2**(DW-1));
`else
  // Wrapping keeps only the low DW bits, so the sum is carried at that width.
  localparam int SW = DW;
`endif

  logic signed [DW-1:0] buf_i [MAX_DELAY];
  logic signed [DW-1:0] buf_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] buf_vld;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  logic signed [DW-1:0] tap_i, tap_q;
  logic                 tap_vld;
  logic signed [DW-1:0] s1_i, s1_q;
  logic                 s1_vld;
  logic signed [DW:0]   ext_i, ext_q, rot_i, rot_q;
  logic signed [DW:0]   s2_i, s2_q;
  logic                 s2_vld;
  logic [15:0]          lfsr_i, lfsr_q;
  logic [NOISE_W-1:0]   noise_i, noise_q;
  logic signed [SW-1:0] sum_i, sum_q;
  logic [DW:0]          shp_i, shp_q;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Returns {clipped, value}.
  function automatic logic [DW:0] shape(input logic signed [SW-1:0] s);
`ifdef CHAN_SATURATE_EN
    if (s > SAT_MAX)      shape = {1'b1, DW'(SAT_MAX)};
    else if (s < SAT_MIN) shape = {1'b1, DW'(SAT_MIN)};
    else                  shape = {1'b0, s[DW-1:0]};
`else
    shape = {1'b0, s};
`endif
  endfunction

  // Stage 1: circular delay line; valid bits are cleared on reset, data is not.
  assign rd_ptr = wr_ptr - DELAY;

  always_comb begin
    tap_vld = DAC_vld;
    tap_i   = DAC_I;
    tap_q   = DAC_Q;
    if (DELAY != '0) begin
      tap_vld = buf_vld[rd_ptr];
      tap_i   = buf_i[rd_ptr];
      tap_q   = buf_q[rd_ptr];
    end
  end

  always_ff @(posedge clk_16M384) begin
    buf_i[wr_ptr] <= DAC_I;
    buf_q[wr_ptr] <= DAC_Q;
    if (rst_16M384) begin
      wr_ptr  <= '0;
      buf_vld <= '0;
    end else begin
      wr_ptr          <= wr_ptr + 1'b1;
      buf_vld[wr_ptr] <= DAC_vld;
    end
  end

  // Stage 2: one extra bit so that negating the most negative sample is exact.
  assign ext_i = {s1_i[DW-1], s1_i};
  assign ext_q = {s1_q[DW-1], s1_q};

  always_comb begin
    rot_i = ext_i;
    rot_q = ext_q;
    case (ROT)
      2'd1:    begin rot_i = ext_q;  rot_q = -ext_i; end
      2'd2:    begin rot_i = -ext_i; rot_q = -ext_q; end
      2'd3:    begin rot_i = -ext_q; rot_q = ext_i;  end
      default: begin rot_i = ext_i;  rot_q = ext_q;  end
    endcase
  end

  always_ff @(posedge clk_16M384) begin
    s1_i <= tap_i;
    s1_q <= tap_q;
    s2_i <= rot_i >>> GAIN_SHIFT;
    s2_q <= rot_q >>> GAIN_SHIFT;
    if (rst_16M384) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= tap_vld;
      s2_vld <= s1_vld;
    end
  end

  // Stage 3: noise uses the LFSR state from before this cycle's advance.
  assign noise_i = NOISE_EN ? lfsr_i[NOISE_W-1:0] : '0;
  assign noise_q = NOISE_EN ? lfsr_q[NOISE_W-1:0] : '0;
  assign sum_i   = SW'(s2_i) + SW'(DC_OFFSET) + SW'(noise_i);
  assign sum_q   = SW'(s2_q) + SW'(DC_OFFSET) + SW'(noise_q);
  assign shp_i   = shape(sum_i);
  assign shp_q   = shape(sum_q);

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      lfsr_i   <= SEED_I;
      lfsr_q   <= SEED_Q;
      ADC_I    <= '0;
      ADC_Q    <= '0;
      ADC_vld  <= 1'b0;
      SAT_FLAG <= 1'b0;
    end else begin
      lfsr_i <= lfsr_next(lfsr_i);
      lfsr_q <= lfsr_next(lfsr_q);
      if (s2_vld) begin
        ADC_I    <= shp_i[DW-1:0];
        ADC_Q    <= shp_q[DW-1:0];
        ADC_vld  <= 1'b1;
        SAT_FLAG <= shp_i[DW] | shp_q[DW];
      end else begin
        ADC_I    <= '0;
        ADC_Q    <= '0;
        ADC_vld  <= 1'b0;
        SAT_FLAG <= 1'b0;
      end
    end
  end

endmodule
